// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: stall vectors,
// instruction address type and controller state encodings.
package pipe_ctrl_pkg;

    localparam int STALL_W     = 6;
    localparam int INST_ADDR_W = 32;

    typedef logic [STALL_W-1:0]     stall_t;
    typedef logic [INST_ADDR_W-1:0] inst_addr_t;

    // bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb; 1 = hold
    localparam stall_t     STALL_NONE = 6'b000000;
    localparam stall_t     STALL_ID   = 6'b000111;
    localparam stall_t     STALL_EX   = 6'b001111;
    localparam inst_addr_t ZERO_WORD  = 32'h0000_0000;

    typedef enum logic [1:0] {
        CTRL_RUN   = 2'd0,
        CTRL_STALL = 2'd1,
        CTRL_FLUSH = 2'd2
    } ctrl_state_e;

    // An execute-stage stall also covers everything a decode stall would hold.
    function automatic stall_t stall_sel(input logic req_ex, input logic req_id);
        stall_t s;
        s = STALL_NONE;
        if (req_ex)
            s = STALL_EX;
        else if (req_id)
            s = STALL_ID;
        return s;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline stages and the sequencing
// controller; the core side is the master, the controller the slave.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic       stallreq_id;
    logic       stallreq_ex;
    logic       flush_req;
    inst_addr_t flush_pc_i;
    stall_t     stall;
    logic       flush;
    inst_addr_t new_pc;

    modport master (
        output stallreq_id, stallreq_ex, flush_req, flush_pc_i,
        input  stall, flush, new_pc
    );

    modport slave (
        input  stallreq_id, stallreq_ex, flush_req, flush_pc_i,
        output stall, flush, new_pc
    );

endinterface

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at MAX_VAL until
// cleared or reset.
module ctrl_sat_cnt #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (inc && (cnt != MAX_VAL))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stall vector, registered flush/redirect and
// stuck-stall watchdog. Perf counters built only with PIPE_CTRL_PERF_CNT_EN.
//
// state      | meaning
// CTRL_RUN   | no stall, no flush
// CTRL_STALL | a stall request was active last cycle
// CTRL_FLUSH | flush pulse is being driven
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_TIMEOUT = 64,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    pipe_ctrl_if.slave       pif,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int TMR_W = $clog2(STALL_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(STALL_TIMEOUT);

    ctrl_state_e      state_q, state_d;
    stall_t           stall_c;
    inst_addr_t       new_pc_q;
    logic             timeout_q;
    logic             stalled;
    logic [TMR_W-1:0] timer;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CTRL_RUN;
            new_pc_q  <= ZERO_WORD;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (pif.flush_req)
                new_pc_q <= pif.flush_pc_i;
            timeout_q <= timeout_q | (timer == TMR_MAX);
        end
    end

    // Flushed instructions are being squashed, so their stall requests are masked.
    always_comb begin
        stall_c = STALL_NONE;
        state_d = state_q;
        if (rst)
            stall_c = STALL_NONE;
        else if (pif.flush_req || (state_q == CTRL_FLUSH))
            stall_c = STALL_NONE;
        else
            stall_c = stall_sel(pif.stallreq_ex, pif.stallreq_id);

        if (pif.flush_req)
            state_d = CTRL_FLUSH;
        else if (state_q == CTRL_FLUSH)
            state_d = CTRL_RUN;
        else if (pif.stallreq_ex || pif.stallreq_id)
            state_d = CTRL_STALL;
        else
            state_d = CTRL_RUN;
    end

    assign stalled       = (stall_c != STALL_NONE);
    assign pif.stall     = stall_c;
    assign pif.flush     = (state_q == CTRL_FLUSH);
    assign pif.new_pc    = new_pc_q;
    assign stall_timeout = timeout_q;

    ctrl_sat_cnt #(
        .WIDTH   (TMR_W),
        .MAX_VAL (TMR_MAX)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .inc (stalled),
        .clr (!stalled),
        .cnt (timer)
    );

`ifdef PIPE_CTRL_PERF_CNT_EN
    ctrl_sat_cnt #(
        .WIDTH   (CNT_W),
        .MAX_VAL ({CNT_W{1'b1}})
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stalled),
        .clr (1'b0),
        .cnt (stall_cycles)
    );

    ctrl_sat_cnt #(
        .WIDTH   (CNT_W),
        .MAX_VAL ({CNT_W{1'b1}})
    ) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (pif.flush),
        .clr (1'b0),
        .cnt (flush_count)
    );
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl; perf-counter expectations follow
// PIPE_CTRL_PERF_CNT_EN (CNT_W=2 when defined).
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

`ifdef PIPE_CTRL_PERF_CNT_EN
    localparam int TB_CNT_W = 2;
    localparam bit PERF     = 1'b1;
`else
    localparam int TB_CNT_W = 16;
    localparam bit PERF     = 1'b0;
`endif

    localparam int SEL_STALL   = 0;
    localparam int SEL_FLUSH   = 1;
    localparam int SEL_NEWPC   = 2;
    localparam int SEL_TIMEOUT = 3;
    localparam int SEL_SCYC    = 4;
    localparam int SEL_FCNT    = 5;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    logic                clk;
    logic                rst;
    logic                stall_timeout;
    logic [TB_CNT_W-1:0] stall_cycles;
    logic [TB_CNT_W-1:0] flush_count;
    exp_t                sb[$];
    int                  n_assert;
    int                  n_fail;

    pipe_ctrl_if pif ();

    pipe_ctrl #(
        .STALL_TIMEOUT (4),
        .CNT_W         (TB_CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pif           (pif),
        .stall_timeout (stall_timeout),
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of test, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] pexp(input logic [31:0] v);
        return PERF ? v : 32'd0;
    endfunction

    function automatic logic [31:0] observe(input int sel);
        logic [31:0] v;
        v = '0;
        case (sel)
            SEL_STALL:   v = 32'(pif.stall);
            SEL_FLUSH:   v = 32'(pif.flush);
            SEL_NEWPC:   v = pif.new_pc;
            SEL_TIMEOUT: v = 32'(stall_timeout);
            SEL_SCYC:    v = 32'(stall_cycles);
            SEL_FCNT:    v = 32'(flush_count);
            default:     v = 'x;
        endcase
        return v;
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check_sb();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            n_assert++;
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic drive(input logic id, input logic ex, input logic fr, input logic [31:0] pc);
        pif.stallreq_id = id;
        pif.stallreq_ex = ex;
        pif.flush_req   = fr;
        pif.flush_pc_i  = pc;
    endtask

    task automatic settle();
        #1;
        check_sb();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_sb();
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;

        // reset: stall masked even with a request present
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        push("rst_stall", SEL_STALL, 32'h00);
        settle();
        tick();
        push("rst_flush", SEL_FLUSH, 32'd0);
        push("rst_newpc", SEL_NEWPC, 32'd0);
        push("rst_timeout", SEL_TIMEOUT, 32'd0);
        push("rst_scyc", SEL_SCYC, 32'd0);
        push("rst_fcnt", SEL_FCNT, 32'd0);
        tick();

        // decode stall for 3 cycles
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            push("id_stall", SEL_STALL, 32'h07);
            settle();
            push("id_timeout", SEL_TIMEOUT, 32'd0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        push("id_release", SEL_STALL, 32'h00);
        settle();
        push("id_scyc", SEL_SCYC, pexp(32'd3));
        tick();

        // ex over id, then id alone the same cycle ex drops
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        push("ex_id_stall", SEL_STALL, 32'h0F);
        settle();
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        push("id_after_ex", SEL_STALL, 32'h07);
        settle();
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        push("idle_stall", SEL_STALL, 32'h00);
        settle();
        push("scyc_sat", SEL_SCYC, pexp(32'd3));
        tick();

        // flush over an execute stall
        drive(1'b0, 1'b1, 1'b1, 32'hBFC0_0380);
        push("flush_mask", SEL_STALL, 32'h00);
        settle();
        push("flush_pulse", SEL_FLUSH, 32'd1);
        push("flush_pc", SEL_NEWPC, 32'hBFC0_0380);
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        push("flush_state_mask", SEL_STALL, 32'h00);
        settle();
        push("flush_end", SEL_FLUSH, 32'd0);
        push("fcnt_one", SEL_FCNT, pexp(32'd1));
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        push("post_flush_stall", SEL_STALL, 32'h00);
        settle();
        tick();

        // back-to-back flushes, latest address wins
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0100);
        settle();
        push("b2b_flush1", SEL_FLUSH, 32'd1);
        push("b2b_pc1", SEL_NEWPC, 32'h0000_0100);
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0200);
        settle();
        push("b2b_flush2", SEL_FLUSH, 32'd1);
        push("b2b_pc2", SEL_NEWPC, 32'h0000_0200);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        settle();
        push("b2b_end", SEL_FLUSH, 32'd0);
        tick();

        // watchdog: 4 stalled cycles reaches STALL_TIMEOUT=4
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0);
            push("to_stall", SEL_STALL, 32'h0F);
            settle();
            if (i < 3)
                push("to_early", SEL_TIMEOUT, 32'd0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        settle();
        push("to_set", SEL_TIMEOUT, 32'd1);
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'hBFC0_0000);
        settle();
        push("to_flush", SEL_FLUSH, 32'd1);
        push("to_sticky_flush", SEL_TIMEOUT, 32'd1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        settle();
        push("to_sticky", SEL_TIMEOUT, 32'd1);
        push("scyc_end", SEL_SCYC, pexp(32'd3));
        push("fcnt_sat", SEL_FCNT, pexp(32'd3));
        tick();

        // reset in the middle of a flush pulse
        drive(1'b0, 1'b0, 1'b1, 32'hDEAD_0000);
        settle();
        push("mid_flush", SEL_FLUSH, 32'd1);
        tick();
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 32'h1234_5678);
        push("rst_mid_stall", SEL_STALL, 32'h00);
        settle();
        push("rst_abort_flush", SEL_FLUSH, 32'd0);
        push("rst_abort_pc", SEL_NEWPC, 32'd0);
        push("rst_clr_timeout", SEL_TIMEOUT, 32'd0);
        push("rst_clr_scyc", SEL_SCYC, 32'd0);
        push("rst_clr_fcnt", SEL_FCNT, 32'd0);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        settle();
        push("post_rst_flush", SEL_FLUSH, 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
